// File: rtl/sha3_miner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_miner_pkg
//  Description : Register map, control field positions and widths shared by
//                the SHA3 miner CSR block and its users.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha3_miner_pkg;

    localparam int C_DATA_W     = 32;
    localparam int C_ADDR_W     = 5;
    localparam int C_HEADER_W   = 256;
    localparam int C_DIFF_W     = 256;
    localparam int C_NONCE_W    = 64;
    localparam int C_CONTROL_W  = 19;
    localparam int C_STATUS_W   = 3;
    localparam int C_SOLUTION_W = 64;

    typedef logic [C_ADDR_W-1:0] csr_addr_t;

    localparam csr_addr_t C_ADDR_NONCE_LO = 5'd16;
    localparam csr_addr_t C_ADDR_NONCE_HI = 5'd17;
    localparam csr_addr_t C_ADDR_CONTROL  = 5'd18;
    localparam csr_addr_t C_ADDR_STATUS   = 5'd19;
    localparam csr_addr_t C_ADDR_SOL_LO   = 5'd20;
    localparam csr_addr_t C_ADDR_SOL_HI   = 5'd21;
    localparam csr_addr_t C_ADDR_IRQ_CTL  = 5'd22;
    localparam csr_addr_t C_ADDR_RUN_CNT  = 5'd23;

    // control[] field positions
    localparam int C_CTRL_RUN      = 0;
    localparam int C_CTRL_TEST     = 1;
    localparam int C_CTRL_HALT     = 2;
    localparam int C_CTRL_PADL_LSB = 3;
    localparam int C_CTRL_PADL_MSB = 10;
    localparam int C_CTRL_PADF_LSB = 11;
    localparam int C_CTRL_PADF_MSB = 18;

    localparam int C_STATUS_WP_ERR_BIT = 4;
    localparam int C_IRQ_PENDING_BIT   = 0;
    localparam int C_IRQ_ENABLE_BIT    = 1;

endpackage
`default_nettype wire

// File: rtl/sha3_miner_csr_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_miner_csr_if
//  Description : Avalon-MM style slave bus (no waitrequest, fixed 1-cycle
//                read latency) for the SHA3 miner CSR block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha3_miner_csr_if;
    import sha3_miner_pkg::*;

    logic [C_ADDR_W-1:0] avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [C_DATA_W-1:0] avs_writedata;
    logic [C_DATA_W-1:0] avs_readdata;
    logic                avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );

endinterface
`default_nettype wire

// File: rtl/sha3_miner_csr.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_miner_csr
//  Description : Host-facing control/status registers for the SHA3 miner:
//                job setup, write protection while running, interrupt logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha3_miner_csr
    import sha3_miner_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,
    sha3_miner_csr_if.slave              avs,
    output logic                         irq_out,
    output logic [C_HEADER_W-1:0]        header,
    output logic [C_DIFF_W-1:0]          difficulty,
    output logic [C_NONCE_W-1:0]         start_nonce,
    output logic [C_CONTROL_W-1:0]       control,
    input  wire logic [C_SOLUTION_W-1:0] solution,
    input  wire logic [C_STATUS_W-1:0]   status,
    input  wire logic                    miner_irq
);

    logic [C_HEADER_W-1:0]  r_header;
    logic [C_DIFF_W-1:0]    r_difficulty;
    logic [C_NONCE_W-1:0]   r_start_nonce;
    logic [C_CONTROL_W-1:0] r_control;
    logic [C_DATA_W-1:0]    r_shadow;
    logic [C_DATA_W-1:0]    r_run_cnt;
    logic [C_DATA_W-1:0]    r_readdata;
    logic                   r_readdatavalid;
    logic                   r_pending;
    logic                   r_enable;
    logic                   r_wp_err;
    logic                   r_irq_out;
    logic                   r_miner_irq_d;

    csr_addr_t              w_addr;
    logic [C_DATA_W-1:0]    w_wdata;
    logic                   w_wr;
    logic                   w_wp_block;
    logic                   w_cfg_wr;
    logic                   w_irq_rise;
    logic                   w_run_rise;
    logic [7:0]             w_bit_base;
    logic [C_DATA_W-1:0]    w_rdata;

    assign w_addr     = avs.avs_address;
    assign w_wdata    = avs.avs_writedata;
    assign w_wr       = avs.avs_write;
    assign w_bit_base = {w_addr[2:0], 5'b0_0000};

    // Job parameters (addresses below control) are frozen while the miner runs
    assign w_wp_block = r_control[C_CTRL_RUN] && (w_addr < C_ADDR_CONTROL);
    assign w_cfg_wr   = w_wr && !w_wp_block;
    assign w_irq_rise = miner_irq && !r_miner_irq_d;
    assign w_run_rise = w_wr && (w_addr == C_ADDR_CONTROL)
                        && w_wdata[C_CTRL_RUN] && !r_control[C_CTRL_RUN];

    always_comb begin
        w_rdata = '0;
        case (w_addr[4:3])
            2'b00:   w_rdata = r_header[w_bit_base +: C_DATA_W];
            2'b01:   w_rdata = r_difficulty[w_bit_base +: C_DATA_W];
            default: begin
                case (w_addr)
                    C_ADDR_NONCE_LO: w_rdata = r_start_nonce[31:0];
                    C_ADDR_NONCE_HI: w_rdata = r_start_nonce[63:32];
                    C_ADDR_CONTROL:  w_rdata = {{(C_DATA_W-C_CONTROL_W){1'b0}}, r_control};
                    C_ADDR_STATUS:   w_rdata = {27'b0, r_wp_err, r_pending, status};
                    C_ADDR_SOL_LO:   w_rdata = solution[31:0];
                    C_ADDR_SOL_HI:   w_rdata = r_shadow;
                    C_ADDR_IRQ_CTL:  w_rdata = {30'b0, r_enable, r_pending};
                    C_ADDR_RUN_CNT:  w_rdata = r_run_cnt;
                    default:         w_rdata = '0;
                endcase
            end
        endcase
    end

    // Read path samples pre-write state, so a same-cycle write is not visible
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_shadow        <= '0;
        end else begin
            r_readdatavalid <= avs.avs_read;
            if (avs.avs_read) begin
                r_readdata <= w_rdata;
                if (w_addr == C_ADDR_SOL_LO) begin
                    r_shadow <= solution[63:32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_header      <= '0;
            r_difficulty  <= '0;
            r_start_nonce <= '0;
            r_control     <= '0;
        end else if (w_cfg_wr) begin
            case (w_addr[4:3])
                2'b00:   r_header[w_bit_base +: C_DATA_W]     <= w_wdata;
                2'b01:   r_difficulty[w_bit_base +: C_DATA_W] <= w_wdata;
                default: begin
                    case (w_addr)
                        C_ADDR_NONCE_LO: r_start_nonce[31:0]  <= w_wdata;
                        C_ADDR_NONCE_HI: r_start_nonce[63:32] <= w_wdata;
                        C_ADDR_CONTROL: begin
                            r_control[C_CTRL_RUN]  <= w_wdata[C_CTRL_RUN];
                            r_control[C_CTRL_TEST] <= w_wdata[C_CTRL_TEST];
                            r_control[C_CTRL_HALT] <= w_wdata[C_CTRL_HALT];
                            r_control[C_CTRL_PADL_MSB:C_CTRL_PADL_LSB] <=
                                w_wdata[C_CTRL_PADL_MSB:C_CTRL_PADL_LSB];
                            r_control[C_CTRL_PADF_MSB:C_CTRL_PADF_LSB] <=
                                w_wdata[C_CTRL_PADF_MSB:C_CTRL_PADF_LSB];
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp_err      <= 1'b0;
            r_pending     <= 1'b0;
            r_enable      <= 1'b0;
            r_irq_out     <= 1'b0;
            r_miner_irq_d <= 1'b0;
        end else begin
            r_miner_irq_d <= miner_irq;
            r_irq_out     <= r_pending & r_enable;
            if (w_wr && w_wp_block) begin
                r_wp_err <= 1'b1;
            end else if (w_wr && (w_addr == C_ADDR_STATUS) && w_wdata[C_STATUS_WP_ERR_BIT]) begin
                r_wp_err <= 1'b0;
            end
            // A new miner event outranks a simultaneous host acknowledge
            if (w_irq_rise) begin
                r_pending <= 1'b1;
            end else if (w_wr && (w_addr == C_ADDR_IRQ_CTL) && w_wdata[C_IRQ_PENDING_BIT]) begin
                r_pending <= 1'b0;
            end
            if (w_wr && (w_addr == C_ADDR_IRQ_CTL)) begin
                r_enable <= w_wdata[C_IRQ_ENABLE_BIT];
            end
        end
    end

    // Counts cycles spent mining; frozen once the miner signals or is halted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (w_run_rise) begin
            r_run_cnt <= '0;
        end else if (r_control[C_CTRL_RUN] && !r_control[C_CTRL_HALT]
                     && !miner_irq && (r_run_cnt != '1)) begin
            r_run_cnt <= r_run_cnt + 32'd1;
        end
    end

    assign header                = r_header;
    assign difficulty            = r_difficulty;
    assign start_nonce           = r_start_nonce;
    assign control               = r_control;
    assign irq_out               = r_irq_out;
    assign avs.avs_readdata      = r_readdata;
    assign avs.avs_readdatavalid = r_readdatavalid & ~rst;

endmodule
`default_nettype wire

// File: doc/sha3_miner_csr.md
SHA3_MINER_CSR -- requirements
Module: sha3_miner_csr

Interface
REQ-001 SHALL provide: clk  in  1  clock; all logic on its rising edge.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: avs_address  in  5  word address.
REQ-004 SHALL provide: avs_read / avs_write  in  1 each  bus strobes.
REQ-005 SHALL provide: avs_writedata  in  32  write data; avs_readdata  out  32  read data; avs_readdatavalid  out  1  read data qualifier.
REQ-006 SHALL provide: irq_out  out  1  interrupt to host.
REQ-007 SHALL provide miner-facing ports: header out 256; difficulty out 256; start_nonce out 64; control out 19; solution in 64; status in 3 ({test, run, found}); miner_irq in 1.

Function
REQ-008 SHALL decode word addresses:
- 0-7: header[32k+31:32k], RW.
- 8-15: difficulty words 0-7, RW.
- 16-17: start_nonce lo/hi, RW.
- 18: control[18:0], RW; bits 31:19 read 0.
- 19: status, RO = {27'b0, wp_err, pending, status[2:0]}.
- 20-21: solution lo/hi, RO.
- 22: irq_ctl = {30'b0, enable, pending}.
- 23: run-cycle counter, RO.
- 24-31: read 0; writes ignored.
REQ-009 SHALL return avs_readdata and pulse avs_readdatavalid exactly 1 cycle after avs_read; avs_readdatavalid is low otherwise; there is no waitrequest.
REQ-010 SHALL, on simultaneous read and write, apply the write and return the pre-write value.
REQ-011 SHALL drop writes to addresses 0-17 while control[0]=1 (run), and set sticky wp_err; writing 1 to status bit 4 clears wp_err.
REQ-012 SHALL snapshot solution[63:32] into a shadow register when address 20 is read; a read of address 21 returns the shadow, giving a coherent 64-bit value.
REQ-013 SHALL set pending on the rising edge of miner_irq (edge detector registered in clk).
REQ-014 SHALL clear pending when irq_ctl bit 0 is written with 1; if set and clear occur in the same cycle, set wins.
REQ-015 SHALL write irq_ctl bit 1 as enable; irq_out = pending & enable, registered, with 1-cycle lag from pending.
REQ-016 SHALL clear the run-cycle counter on the rising edge of control[0].
REQ-017 SHALL increment the run-cycle counter each cycle while control[0]=1 and miner_irq=0, saturating at 0xFFFFFFFF.
REQ-018 SHALL hold the counter while the miner is halted or stopped.
REQ-019 SHALL drive header, difficulty, start_nonce and control directly from registers, with no combinational path from the bus.

Reset
REQ-020 SHALL, on rst, clear all registers to 0: header, difficulty, start_nonce, control, shadow, counter, pending, enable, wp_err, avs_readdata, avs_readdatavalid, irq_out.
REQ-021 SHALL, on rst mid-read, suppress that read's avs_readdatavalid.

Structure
REQ-022 SHALL place register address constants, field bit positions (run=0, test=1, halt=2, padl=10:3, padf=18:11) and widths in shared package sha3_miner_pkg.
REQ-023 SHALL be a single module with no sub-modules; the miner is instantiated by the parent.

Verification
REQ-024 SHALL cover: write 0xDEADBEEF to address 3 -> header[127:96]=0xDEADBEEF; read address 3 -> readdatavalid 1 cycle later with 0xDEADBEEF.
REQ-025 SHALL cover: control=0x1 written, then write address 0 -> header unchanged, status bit 4=1; write 0x10 to address 19 -> bit 4=0.
REQ-026 SHALL cover: solution=0x11223344_55667788, read address 20 (0x55667788), then change solution to 0, read address 21 -> 0x11223344.
REQ-027 SHALL cover: enable=1, miner_irq rises -> pending=1, irq_out=1 next cycle; write 0x3 to address 22 on the same cycle as a new miner_irq edge -> pending stays 1.
REQ-028 SHALL cover: run set, miner_irq after 100 cycles -> counter reads 100 and holds; run cleared then set -> counter restarts at 0.
REQ-029 SHALL cover: rst asserted the cycle after avs_read -> no readdatavalid; all outputs 0.
